// File: rtl/morphle_port_driver.sv
// Host-side port driving a row of Morphle columns from the top edge.
// Each input word goes out dual-rail (01 = zero, 10 = one). The port waits for
// every column to answer, captures the answer, then returns the pairs to empty.
// The upward rails are asynchronous and pass through synchronizer flops.
module morphle_port_driver #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic [2*WIDTH-1:0] dout,
    input  logic [2*WIDTH-1:0] uin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_err,
    output logic               stuck
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StDrive, StRtz} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0][2*WIDTH-1:0] sync_q;
    logic [2*WIDTH-1:0] s;
    logic [2*WIDTH-1:0] s_prev_q;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] dout_q, dout_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_err_q, out_err_d;
    logic               stuck_q, stuck_d;

    logic [2*WIDTH-1:0] enc;
    logic [WIDTH-1:0]   rail1;
    logic               all_full;
    logic               any_illegal;
    logic               all_empty;
    logic               complete;
    logic               timeout;
    logic               accept;

    assign s         = sync_q[SYNC_STAGES-1];
    // Identical non-empty samples on two cycles: dual-rail only moves monotonically,
    // so a repeat means every column's skewed rails have settled.
    assign complete  = all_full && (s == s_prev_q);
    assign all_empty = (s == '0) && (s_prev_q == '0);
    assign timeout   = (cnt_q == CntW'(TIMEOUT - 1));
    assign in_ready  = (state_q == StIdle) && !out_valid_q && !reset;
    assign accept    = in_valid && in_ready;

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign stuck     = stuck_q;

    // Synchronize upward rails; keep the previous synchronized sample for stability checks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            s_prev_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], uin};
            s_prev_q <= s;
        end
    end

    // Per-column encode of the input word and decode of the synchronized answer.
    always_comb begin
        enc         = '0;
        rail1       = '0;
        all_full    = 1'b1;
        any_illegal = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            enc[2*i +: 2] = in_data[i] ? 2'b10 : 2'b01;
            rail1[i]      = s[2*i+1];
            all_full      = all_full & (|s[2*i +: 2]);
            any_illegal   = any_illegal | (&s[2*i +: 2]);
        end
    end

    // Next-state, drive, capture and handshake logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        stuck_d     = stuck_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_err_d   = 1'b0;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = StDrive;
                    dout_d  = enc;
                end
            end
            StDrive: begin
                cnt_d = cnt_q + 1'b1;
                if (complete || timeout) begin
                    state_d     = StRtz;
                    cnt_d       = '0;
                    dout_d      = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = complete ? rail1 : '0;
                    out_err_d   = complete ? any_illegal : 1'b1;
                end
            end
            StRtz: begin
                cnt_d  = cnt_q + 1'b1;
                dout_d = '0;
                if (all_empty) begin
                    state_d = StIdle;
                end else if (timeout) begin
                    state_d = StIdle;
                    stuck_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                dout_d  = '0;
            end
        endcase
    end

    // State register; reset forces the column drive empty immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            stuck_q     <= stuck_d;
        end
    end

endmodule

// File: tb/tb_morphle_port_driver.sv
// Scoreboard bench for morphle_port_driver with a behavioural column-row model.
module tb_morphle_port_driver;

    localparam int W  = 4;
    localparam int TO = 20;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic [2*W-1:0]   dout;
    logic [2*W-1:0]   uin = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic             out_err;
    logic             stuck;

    morphle_port_driver #(
        .WIDTH      (W),
        .SYNC_STAGES(2),
        .TIMEOUT    (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .dout     (dout),
        .uin      (uin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err),
        .stuck    (stuck)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit bp = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Column row model: mode 0 echo, 1 answer 11, 2 never answer, 3 hold answer forever.
    int         dly[W];
    int         mode[W];
    logic [1:0] held[W];
    logic [2*W-1:0] hist[64];
    int         ncyc = 0;

    initial begin
        for (int i = 0; i < 64; i++) hist[i] = '0;
        for (int i = 0; i < W; i++) begin
            dly[i] = 1; mode[i] = 0; held[i] = 2'b00;
        end
    end

    always @(negedge clk) begin
        logic [2*W-1:0] h;
        logic [1:0]     p;
        int             idx;
        hist[ncyc % 64] = dout;
        for (int i = 0; i < W; i++) begin
            idx = ncyc - dly[i];
            h   = (idx < 0) ? '0 : hist[idx % 64];
            p   = h[2*i +: 2];
            case (mode[i])
                1: if (p != 2'b00) p = 2'b11;
                2: p = 2'b00;
                3: begin
                    if (p != 2'b00) held[i] = p;
                    p = held[i];
                end
                default: ;
            endcase
            uin[2*i +: 2] = p;
        end
        ncyc++;
    end

    always @(posedge clk) begin
        #1;
        out_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           acc;
        int           lat;
        bit           exact;
    } exp_t;
    exp_t sbq[$];

    // Monitor: latency on rise of out_valid, data/err on each handshake.
    bit ov_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        int   el;
        if (reset) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid) chk("dout_empty_while_valid", 32'(dout), 32'h0);
            if (out_valid && !ov_prev) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid", 32'(sbq.size()), 32'h1);
                end else begin
                    e  = sbq[0];
                    el = cyc - e.acc;
                    if (e.exact) chk("timeout_latency", 32'(el), 32'(e.lat));
                    else chk("no_early_capture", 32'(el >= e.lat), 32'h1);
                end
            end
            if (out_valid && out_ready && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_err", 32'(out_err), 32'(e.err));
            end
            ov_prev = out_valid;
        end
    end

    function automatic logic [2*W-1:0] enc(input logic [W-1:0] d);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) r[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    task automatic set_cols(input int m0, input int m1, input int m2, input int m3);
        mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
        for (int i = 0; i < W; i++) held[i] = 2'b00;
    endtask

    task automatic send(input logic [W-1:0] d);
        int   n = 0;
        int   maxd = 0;
        bit   mute = 1'b0;
        logic [W-1:0] ill = '0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(in_ready), 32'h1);
        if (!in_ready) return;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        for (int i = 0; i < W; i++) begin
            if (mode[i] == 2) mute = 1'b1;
            else if (dly[i] > maxd) maxd = dly[i];
            if (mode[i] == 1) ill[i] = 1'b1;
        end
        e.acc = cyc;
        if (mute) begin
            e.data = '0; e.err = 1'b1; e.lat = TO; e.exact = 1'b1;
        end else begin
            e.data = d | ill; e.err = |ill; e.lat = maxd + 4; e.exact = 1'b0;
        end
        sbq.push_back(e);
        chk("dout_encoded", 32'(dout), 32'(enc(d)));
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((sbq.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(sbq.size() == 0 && in_ready), 32'h1);
    endtask

    initial begin
        logic [W-1:0] d0;
        int n;

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_err", 32'(out_err), 32'h0);
        chk("rst_stuck", 32'(stuck), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Basic transfer, staggered echo.
        dly[0] = 3; dly[1] = 4; dly[2] = 5; dly[3] = 6;
        set_cols(0, 0, 0, 0);
        send(4'b1010);
        wait_drain();

        // Skewed columns.
        dly[0] = 1; dly[1] = 5; dly[2] = 9; dly[3] = 12;
        send(4'b0110);
        wait_drain();

        // Illegal 11 on column 2, then a normal word to show RTZ completed.
        dly[0] = 2; dly[1] = 3; dly[2] = 4; dly[3] = 2;
        set_cols(0, 0, 1, 0);
        send(4'b0001);
        wait_drain();
        set_cols(0, 0, 0, 0);
        send(4'b1111);
        wait_drain();

        // Column 3 never answers.
        set_cols(0, 0, 0, 2);
        send(4'b1011);
        wait_drain();
        set_cols(0, 0, 0, 0);

        // Backpressure: result must hold and no new word accepted.
        bp = 1'b1;
        send(4'b1100);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 32'(out_valid), 32'h1);
        d0 = out_data;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk("bp_data_stable", 32'(out_data), 32'(d0));
            chk("bp_in_ready_low", 32'(in_ready), 32'h0);
        end
        bp = 1'b0;
        wait_drain();

        // Columns hold their answer through RTZ: stuck must set and port go idle.
        set_cols(3, 3, 3, 3);
        send(4'b0101);
        n = 0;
        while (!stuck && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stuck_set", 32'(stuck), 32'h1);
        wait_drain();
        set_cols(0, 0, 0, 0);
        repeat (30) @(negedge clk);
        chk("stuck_sticky", 32'(stuck), 32'h1);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            int r;
            for (int i = 0; i < W; i++) dly[i] = $urandom_range(1, 10);
            set_cols(0, 0, 0, 0);
            r = $urandom_range(0, 9);
            if (r == 0) mode[$urandom_range(0, W - 1)] = 2;
            else if (r == 1) mode[$urandom_range(0, W - 1)] = 1;
            send(W'($urandom));
            wait_drain();
        end
        set_cols(0, 0, 0, 0);

        // Asynchronous reset in the middle of DRIVE.
        set_cols(0, 0, 0, 2);
        send(4'b1001);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_dout", 32'(dout), 32'h0);
        chk("areset_out_valid", 32'(out_valid), 32'h0);
        sbq.delete();
        set_cols(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'h1);
        chk("post_reset_stuck", 32'(stuck), 32'h0);
        chk("post_reset_out_valid", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
